// File: rtl/spi_master_ctrl_if.sv
// Host request/response and SPI pin bundle for spi_master_ctrl.
interface spi_master_ctrl_if;
  logic        start;
  logic        write;
  logic [15:0] wdata;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] rdata;
  logic        SCLK;
  logic        CS_n;
  logic        MOSI;
  logic        MISO;

  modport master (
    input  start, write, wdata, MISO,
    output ready, busy, done, rdata, SCLK, CS_n, MOSI
  );

  modport slave (
    output start, write, wdata, MISO,
    input  ready, busy, done, rdata, SCLK, CS_n, MOSI
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master for the 16-bit register peripheral: one 24-bit frame
// (8-bit command + 16 data bits, MSB first) per accepted host request.
module spi_master_ctrl #(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [7:0]  GET_CODE = 8'h50,
  parameter logic [7:0]  PUT_CODE = 8'h46
) (
  input  logic          CLK,
  input  logic          RST_n,
  spi_master_ctrl_if.master bus
);

  localparam int unsigned TW   = $clog2(CLK_DIV) + 1;
  localparam int unsigned BW   = 5;
  localparam logic [TW-1:0] TMAX = TW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LOW, S_HIGH, S_HOLD, S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [22:0]   tx_q, tx_d;
  logic [15:0]   rx_q, rx_d;
  logic          wr_q, wr_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          sclk_q, sclk_d;
  logic          cs_n_q, cs_n_d;
  logic          mosi_q, mosi_d;
  logic          tmr_end_c;
  logic [23:0]   frame_c;

  // Frame to send for the request currently presented by the host.
  assign frame_c   = bus.write ? {PUT_CODE, bus.wdata} : {GET_CODE, 16'hFFFF};
  assign tmr_end_c = (tmr_q == TMAX);

  // Next-state and output decode; each non-idle state lasts one half-period.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_end_c ? '0 : tmr_q + TW'(1);
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    wr_d    = wr_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    unique case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (bus.start && ready_q) begin
          tx_d    = frame_c[22:0];
          wr_d    = bus.write;
          cs_n_d  = 1'b0;
          mosi_d  = frame_c[23];
          ready_d = 1'b0;
          busy_d  = 1'b1;
          bit_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (tmr_end_c) begin
          sclk_d  = 1'b0;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        // Rising edge: sample MISO, present the next frame bit (ones once exhausted).
        if (tmr_end_c) begin
          sclk_d  = 1'b1;
          bit_d   = bit_q + BW'(1);
          tx_d    = {tx_q[21:0], 1'b1};
          mosi_d  = tx_q[22];
          if (!wr_q && (bit_q >= BW'(8))) begin
            rx_d = {rx_q[14:0], bus.MISO};
          end
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (tmr_end_c) begin
          if (bit_q < BW'(24)) begin
            sclk_d  = 1'b0;
            state_d = S_LOW;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (tmr_end_c) begin
          cs_n_d  = 1'b1;
          mosi_d  = 1'b1;
          done_d  = 1'b1;
          if (!wr_q) begin
            rdata_d = rx_q;
          end
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (tmr_end_c) begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; an aborted frame keeps the last completed GET result.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      wr_q    <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b1;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b1;
      if (!busy_q) begin
        rdata_q <= '0;
      end
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign bus.SCLK  = sclk_q;
  assign bus.CS_n  = cs_n_q;
  assign bus.MOSI  = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench: two controllers (CLK_DIV=4 and CLK_DIV=1), each with a
// behavioural 16-bit SPI register peripheral (power-up value 16'hABCD).
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int unsigned cyc = 0;

  logic [1:0]        start_s, write_s;
  logic [1:0][15:0]  wdata_s;
  logic [1:0]        ready_s, busy_s, done_s, sclk_s, csn_s, mosi_s;
  logic [1:0][15:0]  rdata_s, preg_s;
  logic [1:0][23:0]  cap_s;
  logic [1:0][5:0]   falls_s, rises_s;
  logic [1:0][7:0]   frames_s, dones_s;

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : pg
    spi_master_ctrl_if bus ();

    logic        miso   = 1'b1;
    logic [15:0] preg   = 16'hABCD;
    logic [15:0] dout   = 16'hFFFF;
    logic [23:0] cap    = '0;
    logic [7:0]  cmd    = '0;
    logic [5:0]  falls  = '0;
    logic [5:0]  rises  = '0;
    logic [7:0]  frames = '0;
    logic [7:0]  dones  = '0;
    logic        p_cs   = 1'b1;
    logic        p_sclk = 1'b1;

    assign bus.start = start_s[g];
    assign bus.write = write_s[g];
    assign bus.wdata = wdata_s[g];
    assign bus.MISO  = miso;

    assign ready_s[g]  = bus.ready;
    assign busy_s[g]   = bus.busy;
    assign done_s[g]   = bus.done;
    assign rdata_s[g]  = bus.rdata;
    assign sclk_s[g]   = bus.SCLK;
    assign csn_s[g]    = bus.CS_n;
    assign mosi_s[g]   = bus.MOSI;
    assign preg_s[g]   = preg;
    assign cap_s[g]    = cap;
    assign falls_s[g]  = falls;
    assign rises_s[g]  = rises;
    assign frames_s[g] = frames;
    assign dones_s[g]  = dones;

    spi_master_ctrl #(.CLK_DIV((g == 0) ? 4 : 1)) dut (
      .CLK  (clk),
      .RST_n(rst_n),
      .bus  (bus)
    );

    // Peripheral model: samples MOSI and drives SDO on SCLK falls, commits PUT on CS_n rise.
    always @(negedge clk) begin
      if (p_cs && !bus.CS_n) begin
        falls  = '0;
        rises  = '0;
        cap    = '0;
        cmd    = '0;
        frames = frames + 8'd1;
      end
      if (!bus.CS_n && p_sclk && !bus.SCLK) begin
        falls = falls + 6'd1;
        cap   = {cap[22:0], bus.MOSI};
        if (falls == 6'd8) begin
          cmd  = cap[7:0];
          dout = preg;
        end else if (falls >= 6'd9 && cmd == 8'h50) begin
          miso = dout[15];
          dout = {dout[14:0], 1'b1};
        end
      end
      if (!bus.CS_n && !p_sclk && bus.SCLK) rises = rises + 6'd1;
      if (!p_cs && bus.CS_n) begin
        if (falls == 6'd24 && cmd == 8'h46) preg = cap[15:0];
        miso = 1'b1;
      end
      if (bus.done) dones = dones + 8'd1;
      p_cs   = bus.CS_n;
      p_sclk = bus.SCLK;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_txn(input logic w, input logic wr, input logic [15:0] d,
                           output int unsigned t0);
    int n = 0;
    while (!ready_s[w] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("ready_timeout", 32'(ready_s[w]), 32'd1);
    start_s[w] = 1'b1;
    write_s[w] = wr;
    wdata_s[w] = d;
    @(negedge clk);
    t0 = cyc;
    start_s[w] = 1'b0;
    write_s[w] = 1'($urandom);
    wdata_s[w] = 16'($urandom);
  endtask

  task automatic wait_done(input logic w, input int unsigned t0, input int unsigned lat,
                           input string tag);
    int n = 0;
    while (!done_s[w] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_lat"}, cyc - t0, lat);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done_s[w]), 32'd0);
  endtask

  task automatic wait_ready(input logic w, input int unsigned t0, input int unsigned lat,
                            input string tag);
    int n = 0;
    while (!ready_s[w] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_lat"}, cyc - t0, lat);
    chk({tag, "_busy_low"}, 32'(busy_s[w]), 32'd0);
  endtask

  initial begin
    int unsigned t0;
    int unsigned c0;
    int unsigned dc [3];
    logic [7:0]  f0;
    logic [7:0]  d0;
    int          n;

    rst_n   = 1'b0;
    start_s = '0;
    write_s = '0;
    wdata_s = '0;

    // Reset state of both controllers
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready_s), 32'h3);
    chk("rst_busy",  32'(busy_s),  32'h0);
    chk("rst_done",  32'(done_s),  32'h0);
    chk("rst_csn",   32'(csn_s),   32'h3);
    chk("rst_sclk",  32'(sclk_s),  32'h3);
    chk("rst_mosi",  32'(mosi_s),  32'h3);
    chk("rst_rdata0", 32'(rdata_s[0]), 32'h0);
    chk("rst_rdata1", 32'(rdata_s[1]), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // GET after power-up, CLK_DIV=4
    start_txn(1'b0, 1'b0, 16'h0000, t0);
    chk("get1_csn_low", 32'(csn_s[0]), 32'd0);
    wait_done(1'b0, t0, 200, "get1");
    chk("get1_mosi", 32'(cap_s[0]), 32'h50FFFF);
    chk("get1_falls", 32'(falls_s[0]), 32'd24);
    chk("get1_rises", 32'(rises_s[0]), 32'd24);
    chk("get1_rdata", 32'(rdata_s[0]), 32'hABCD);
    wait_ready(1'b0, t0, 204, "get1");

    // PUT 1234 with an ignored mid-frame start, then GET
    f0 = frames_s[0];
    start_txn(1'b0, 1'b1, 16'h1234, t0);
    repeat (40) @(negedge clk);
    start_s[0] = 1'b1;
    write_s[0] = 1'b0;
    @(negedge clk);
    start_s[0] = 1'b0;
    wait_done(1'b0, t0, 200, "put1");
    chk("put1_mosi", 32'(cap_s[0]), 32'h461234);
    chk("put1_rdata_kept", 32'(rdata_s[0]), 32'hABCD);
    chk("put1_periph", 32'(preg_s[0]), 32'h1234);
    wait_ready(1'b0, t0, 204, "put1");
    chk("put1_frames", 32'(frames_s[0] - f0), 32'd1);
    start_txn(1'b0, 1'b0, 16'hFFFF, t0);
    wait_done(1'b0, t0, 200, "get2");
    chk("get2_rdata", 32'(rdata_s[0]), 32'h1234);
    wait_ready(1'b0, t0, 204, "get2");

    // start held high: back-to-back GETs, 205 cycles apart
    f0 = frames_s[0];
    start_s[0] = 1'b1;
    write_s[0] = 1'b0;
    c0 = cyc;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!done_s[0] && n < 2000) begin
        @(negedge clk);
        n++;
      end
      dc[k] = cyc;
      chk("b2b_rdata", 32'(rdata_s[0]), 32'h1234);
      chk("b2b_falls", 32'(falls_s[0]), 32'd24);
      if (k == 2) start_s[0] = 1'b0;
      @(negedge clk);
    end
    chk("b2b_first_lat", dc[0] - c0, 32'd201);
    chk("b2b_gap01", dc[1] - dc[0], 32'd205);
    chk("b2b_gap12", dc[2] - dc[1], 32'd205);
    repeat (300) @(negedge clk);
    chk("b2b_frames", 32'(frames_s[0] - f0), 32'd3);
    chk("b2b_idle", 32'(ready_s[0]), 32'd1);

    // Reset after the 10th SCLK fall of a PUT
    start_txn(1'b0, 1'b1, 16'h5A5A, t0);
    n = 0;
    while (falls_s[0] != 6'd10 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach10", 32'(falls_s[0]), 32'd10);
    d0 = dones_s[0];
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_csn", 32'(csn_s[0]), 32'd1);
    chk("abort_sclk", 32'(sclk_s[0]), 32'd1);
    chk("abort_mosi", 32'(mosi_s[0]), 32'd1);
    chk("abort_ready", 32'(ready_s[0]), 32'd1);
    chk("abort_rdata", 32'(rdata_s[0]), 32'h1234);
    rst_n = 1'b1;
    repeat (250) @(negedge clk);
    chk("abort_no_done", 32'(dones_s[0] - d0), 32'd0);
    chk("abort_periph", 32'(preg_s[0]), 32'h1234);
    start_txn(1'b0, 1'b0, 16'h0000, t0);
    wait_done(1'b0, t0, 200, "get3");
    chk("get3_rdata", 32'(rdata_s[0]), 32'h1234);
    chk("get3_falls", 32'(falls_s[0]), 32'd24);
    wait_ready(1'b0, t0, 204, "get3");

    // CLK_DIV=1 controller: GET, PUT, GET
    start_txn(1'b1, 1'b0, 16'h0000, t0);
    wait_done(1'b1, t0, 50, "d1_get1");
    chk("d1_get1_mosi", 32'(cap_s[1]), 32'h50FFFF);
    chk("d1_get1_falls", 32'(falls_s[1]), 32'd24);
    chk("d1_get1_rises", 32'(rises_s[1]), 32'd24);
    chk("d1_get1_rdata", 32'(rdata_s[1]), 32'hABCD);
    wait_ready(1'b1, t0, 51, "d1_get1");
    start_txn(1'b1, 1'b1, 16'h1234, t0);
    wait_done(1'b1, t0, 50, "d1_put");
    chk("d1_put_mosi", 32'(cap_s[1]), 32'h461234);
    chk("d1_put_rdata_kept", 32'(rdata_s[1]), 32'hABCD);
    wait_ready(1'b1, t0, 51, "d1_put");
    start_txn(1'b1, 1'b0, 16'h0000, t0);
    wait_done(1'b1, t0, 50, "d1_get2");
    chk("d1_get2_rdata", 32'(rdata_s[1]), 32'h1234);
    wait_ready(1'b1, t0, 51, "d1_get2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
